// File: rtl/score_pkg.sv
// Shared types and constants for the score/lives controller.
//   state_e    : controller FSM state (IDLE, CONV, OVER)
//   SCORE_W    : binary score width
//   LIVES_W    : lives counter width
//   BCD_W      : width of one BCD digit
//   DIGIT_BASE : decimal radix used by the iterative converter
package score_pkg;

  localparam int unsigned SCORE_W    = 7;
  localparam int unsigned LIVES_W    = 2;
  localparam int unsigned BCD_W      = 4;
  localparam int unsigned DIGIT_BASE = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    OVER = 2'd2
  } state_e;

endpackage

// File: rtl/bin_to_bcd_iter.sv
// Iterative binary-to-BCD converter (two digits) by repeated subtract-10.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   clear_i       : synchronous clear to reset values (aborts a conversion)
//   start_i       : load value_i and begin converting
//   value_i       : binary value 0..99
//   busy_o        : conversion in progress
//   done_o        : one-cycle pulse after tens_o/ones_o have been updated
//   tens_o/ones_o : BCD digits, held while busy
module bin_to_bcd_iter
  import score_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               start_i,
  input  logic [SCORE_W-1:0] value_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [BCD_W-1:0]   tens_o,
  output logic [BCD_W-1:0]   ones_o
);

  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [SCORE_W-1:0] work_q, work_d;
  logic [BCD_W-1:0]   acc_q, acc_d;
  logic [BCD_W-1:0]   tens_q, tens_d;
  logic [BCD_W-1:0]   ones_q, ones_d;

  // Register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      work_q <= '0;
      acc_q  <= '0;
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      work_q <= work_d;
      acc_q  <= acc_d;
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  // One subtract-10 step per cycle; publish the digits when the remainder fits.
  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    work_d = work_q;
    acc_d  = acc_q;
    tens_d = tens_q;
    ones_d = ones_q;
    if (clear_i) begin
      busy_d = 1'b0;
      work_d = '0;
      acc_d  = '0;
      tens_d = '0;
      ones_d = '0;
    end else if (start_i) begin
      busy_d = 1'b1;
      work_d = value_i;
      acc_d  = '0;
    end else if (busy_q) begin
      if (work_q >= SCORE_W'(DIGIT_BASE)) begin
        work_d = work_q - SCORE_W'(DIGIT_BASE);
        acc_d  = acc_q + BCD_W'(1);
      end else begin
        tens_d = acc_q;
        ones_d = work_q[BCD_W-1:0];
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign tens_o = tens_q;
  assign ones_o = ones_q;

endmodule

// File: rtl/score_lives_ctrl.sv
// Game-state controller: owns score and lives, accepts kill/hit events via
// valid/ready (hit has priority), drives BCD digits and the lives blink.
// Optional macro SCORE_HIGH_SCORE_EN adds show_hi input and hi_score output.
// Ports:
//   clk, rst                : clock, asynchronous active-high reset
//   clk_display             : display refresh tick (blink pacing)
//   restart                 : synchronous new-game pulse
//   kill_valid/pts/ready    : kill event handshake and points
//   hit_valid/ready         : player-hit event handshake
//   score, lives            : binary score and remaining lives
//   tens, ones, digits_valid: BCD score digits and their validity
//   game_over, lives_blank  : game over flag, lives display blank
module score_lives_ctrl
  import score_pkg::*;
#(
  parameter int unsigned SCORE_MAX   = 99,
  parameter int unsigned LIVES_INIT  = 3,
  parameter int unsigned FLASH_TICKS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_display,
  input  logic               restart,
  input  logic               kill_valid,
  input  logic [3:0]         kill_pts,
  output logic               kill_ready,
  input  logic               hit_valid,
  output logic               hit_ready,
  output logic [SCORE_W-1:0] score,
  output logic [LIVES_W-1:0] lives,
  output logic [BCD_W-1:0]   tens,
  output logic [BCD_W-1:0]   ones,
  output logic               digits_valid,
  output logic               game_over,
  output logic               lives_blank
`ifdef SCORE_HIGH_SCORE_EN
  ,
  input  logic               show_hi,
  output logic [SCORE_W-1:0] hi_score
`endif
);

  localparam int unsigned FLASH_W = $clog2(FLASH_TICKS + 1);

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic               dv_q, dv_d;
  logic               go_q, go_d;
  logic               blank_q, blank_d;
  logic [FLASH_W-1:0] flash_q, flash_d;
`ifdef SCORE_HIGH_SCORE_EN
  logic [SCORE_W-1:0] hi_q, hi_d;
  logic               show_q, show_d;
`endif

  logic               conv_start_c;
  logic [SCORE_W-1:0] conv_val_c;
  logic               conv_busy, conv_done;
  logic               idle_c, hit_acc_c, kill_acc_c;
  logic [7:0]         sum_c;
  logic [SCORE_W-1:0] sat_c;

  // Handshake decode; hit wins over a simultaneous kill, which is held off.
  assign idle_c     = (state_q == IDLE) && !conv_busy;
  assign hit_ready  = idle_c;
  assign kill_ready = idle_c && !hit_valid;
  assign hit_acc_c  = hit_valid && hit_ready;
  assign kill_acc_c = kill_valid && kill_ready;

  // Saturating add done 8 bits wide so score + 15 cannot wrap.
  assign sum_c = 8'(score_q) + 8'(kill_pts);
  assign sat_c = (sum_c > 8'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : sum_c[SCORE_W-1:0];

  // Register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      score_q <= '0;
      lives_q <= LIVES_W'(LIVES_INIT);
      dv_q    <= 1'b1;
      go_q    <= 1'b0;
      blank_q <= 1'b0;
      flash_q <= '0;
`ifdef SCORE_HIGH_SCORE_EN
      hi_q    <= '0;
      show_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      lives_q <= lives_d;
      dv_q    <= dv_d;
      go_q    <= go_d;
      blank_q <= blank_d;
      flash_q <= flash_d;
`ifdef SCORE_HIGH_SCORE_EN
      hi_q    <= hi_d;
      show_q  <= show_d;
`endif
    end
  end

  // Next-state: flash runs on its own, FSM handles events, restart overrides.
  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    lives_d      = lives_q;
    dv_d         = dv_q;
    go_d         = go_q;
    blank_d      = blank_q;
    flash_d      = flash_q;
    conv_start_c = 1'b0;
    conv_val_c   = sat_c;
`ifdef SCORE_HIGH_SCORE_EN
    hi_d         = hi_q;
    show_d       = show_hi;
`endif

    if (clk_display && (flash_q != '0)) begin
      blank_d = ~blank_q;
      flash_d = flash_q - FLASH_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (hit_acc_c) begin
          lives_d = lives_q - LIVES_W'(1);
          blank_d = 1'b0;
          if (lives_q == LIVES_W'(1)) begin
            state_d = OVER;
            go_d    = 1'b1;
            flash_d = '0;
`ifdef SCORE_HIGH_SCORE_EN
            hi_d    = (score_q > hi_q) ? score_q : hi_q;
`endif
          end else begin
            flash_d = FLASH_W'(FLASH_TICKS);
          end
        end else if (kill_acc_c) begin
          score_d      = sat_c;
          conv_start_c = 1'b1;
          dv_d         = 1'b0;
          state_d      = CONV;
        end
      end
      CONV: begin
        if (conv_done) begin
          dv_d    = 1'b1;
          state_d = IDLE;
        end
      end
      OVER: begin
`ifdef SCORE_HIGH_SCORE_EN
        // Re-convert on each show_hi edge so the digits follow the selection.
        if (show_hi != show_q) begin
          conv_start_c = 1'b1;
          conv_val_c   = show_hi ? hi_q : score_q;
          dv_d         = 1'b0;
        end else if (conv_done) begin
          dv_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    if (restart) begin
      state_d      = IDLE;
      score_d      = '0;
      lives_d      = LIVES_W'(LIVES_INIT);
      dv_d         = 1'b1;
      go_d         = 1'b0;
      blank_d      = 1'b0;
      flash_d      = '0;
      conv_start_c = 1'b0;
    end
  end

  bin_to_bcd_iter u_bcd (
    .clk     (clk),
    .rst     (rst),
    .clear_i (restart),
    .start_i (conv_start_c),
    .value_i (conv_val_c),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .tens_o  (tens),
    .ones_o  (ones)
  );

  assign score        = score_q;
  assign lives        = lives_q;
  assign digits_valid = dv_q;
  assign game_over    = go_q;
  assign lives_blank  = blank_q;
`ifdef SCORE_HIGH_SCORE_EN
  assign hi_score     = hi_q;
`endif

endmodule
